seq_lut_loader: RTL and testbench

Host-side configuration loader feeding the sequencer FSM LUT. It accepts a framed byte stream over a valid/ready byte interface and assembles 37-bit LUT entries. It drives the sequencer's LUT write strobe and write data, one pulse per entry, then asserts config done once the frame checksum verifies. It sits directly upstream of the sequencer's `lut_wen_i`, `lut_write_data_i` and `config_done_i` inputs.

---
 rtl/seq_lut_loader.sv | 189 ++++++++++++++++++
 tb/tb_seq_lut_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_lut_loader.sv
// rtl/seq_lut_loader.sv - framed byte-stream loader for the sequencer FSM LUT
//
// Assembles LUT_DATA_WIDTH-bit entries from a framed byte stream and writes
// them into the sequencer LUT. Each frame has the layout
//   HEADER_BYTE, COUNT, N x BPE entry bytes (little-endian), CHK
// where N = COUNT (0 means 256) and CHK is the XOR of COUNT and all entry bytes.
//
// Ports:
//   clk, reset_i         clock, asynchronous active-high reset
//   byte_data_i/valid_i  host byte stream input
//   byte_ready_o         registered; high while a frame can still be accepted
//   abort_i              synchronous abort back to header hunt (ignored once done)
//   lut_wen_o            one-cycle LUT write strobe
//   lut_write_data_o     entry data, held until the next entry completes
//   config_done_o        frame verified; sticky until reset
//   error_o/error_code_o sticky frame error (1 reserved bits, 2 checksum)
//   entries_written_o    LUT writes issued in the current frame
module seq_lut_loader #(
  parameter logic [7:0] HEADER_BYTE    = 8'hA5,
  parameter int         LUT_DATA_WIDTH = 37
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic [7:0]                byte_data_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  input  logic                      abort_i,
  output logic                      lut_wen_o,
  output logic [LUT_DATA_WIDTH-1:0] lut_write_data_o,
  output logic                      config_done_o,
  output logic                      error_o,
  output logic [1:0]                error_code_o,
  output logic [8:0]                entries_written_o
);

  localparam int BPE       = (LUT_DATA_WIDTH + 7) / 8;
  localparam int IDX_W     = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int LAST_BITS = LUT_DATA_WIDTH - (BPE - 1) * 8;
  localparam int PRE_W     = (BPE - 1) * 8;
  // Bits of the final entry byte that lie above the entry width.
  localparam logic [7:0]       RSV_MASK = 8'(9'h1FF << LAST_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPE - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  state_e                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
  logic [PRE_W-1:0]          entry_q, entry_d;
  logic [7:0]                chk_q, chk_d;
  logic [8:0]                n_q, n_d;
  logic [8:0]                cnt_q, cnt_d;
  logic                      wen_q, wen_d;
  logic [LUT_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [1:0]                code_q, code_d;

  logic                      xfer;
  logic [8:0]                cnt_inc;
  logic [LUT_DATA_WIDTH-1:0] assembled;

  assign xfer      = byte_valid_i && ready_q;
  assign cnt_inc   = cnt_q + 9'd1;
  // The first BPE-1 bytes sit in entry_q with byte 0 in the low bits.
  assign assembled = {byte_data_i[LAST_BITS-1:0], entry_q};

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    entry_d    = entry_q;
    chk_d      = chk_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    wen_d      = 1'b0;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    code_d     = code_q;

    // Abort wins over a simultaneous transfer; that byte is dropped.
    if (abort_i && state_q != S_DONE) begin
      state_d    = S_HUNT;
      byte_idx_d = '0;
      chk_d      = 8'd0;
      cnt_d      = 9'd0;
      err_d      = 1'b0;
      code_d     = 2'd0;
    end else if (xfer) begin
      case (state_q)
        S_HUNT: begin
          if (byte_data_i == HEADER_BYTE) begin
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          n_d        = (byte_data_i == 8'd0) ? 9'd256 : {1'b0, byte_data_i};
          chk_d      = byte_data_i;
          byte_idx_d = '0;
          cnt_d      = 9'd0;
          state_d    = S_DATA;
        end
        S_DATA: begin
          chk_d = chk_q ^ byte_data_i;
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            if ((byte_data_i & RSV_MASK) != 8'd0) begin
              err_d   = 1'b1;
              code_d  = 2'd1;
              state_d = S_ERR;
            end else begin
              wen_d   = 1'b1;
              wdata_d = assembled;
              cnt_d   = cnt_inc;
              if (cnt_inc == n_q) begin
                state_d = S_CHECK;
              end
            end
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            entry_d    = {byte_data_i, entry_q[PRE_W-1:8]};
          end
        end
        S_CHECK: begin
          if (byte_data_i == chk_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = S_ERR;
          end
        end
        default: begin
        end
      endcase
    end

    // Registered ready follows the state being entered.
    ready_d = (state_d == S_HUNT) || (state_d == S_COUNT) ||
              (state_d == S_DATA) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_HUNT;
      ready_q    <= 1'b0;
      byte_idx_q <= '0;
      entry_q    <= '0;
      chk_q      <= 8'd0;
      n_q        <= 9'd0;
      cnt_q      <= 9'd0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      byte_idx_q <= byte_idx_d;
      entry_q    <= entry_d;
      chk_q      <= chk_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign byte_ready_o      = ready_q;
  assign lut_wen_o         = wen_q;
  assign lut_write_data_o  = wdata_q;
  assign config_done_o     = done_q;
  assign error_o           = err_q;
  assign error_code_o      = code_q;
  assign entries_written_o = cnt_q;

endmodule

// File: tb/tb_seq_lut_loader.sv
// tb/tb_seq_lut_loader.sv - self-checking bench for seq_lut_loader
module tb_seq_lut_loader;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  byte_data_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        abort_i;
  logic        lut_wen_o;
  logic [36:0] lut_write_data_o;
  logic        config_done_o;
  logic        error_o;
  logic [1:0]  error_code_o;
  logic [8:0]  entries_written_o;

  always #5 clk = ~clk;

  seq_lut_loader #(
    .HEADER_BYTE   (8'hA5),
    .LUT_DATA_WIDTH(37)
  ) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .byte_data_i      (byte_data_i),
    .byte_valid_i     (byte_valid_i),
    .byte_ready_o     (byte_ready_o),
    .abort_i          (abort_i),
    .lut_wen_o        (lut_wen_o),
    .lut_write_data_o (lut_write_data_o),
    .config_done_o    (config_done_o),
    .error_o          (error_o),
    .error_code_o     (error_code_o),
    .entries_written_o(entries_written_o)
  );

  int          compared = 0;
  int          mismatched = 0;
  logic [36:0] exp_q[$];
  int          m_entries = 0;
  int          wen_total = 0;
  int          w0;
  logic [36:0] e_front;
  logic [7:0]  chk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Model: every write must match the next queued expected entry, and the
  // write count must track the number of pulses seen in this frame.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (lut_wen_o) begin
        wen_total++;
        m_entries++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got write of %0h, required none", lut_write_data_o);
        end else begin
          e_front = exp_q.pop_front();
          check("wdata", lut_write_data_o, e_front);
          check("wen_while_done", config_done_o, 0);
        end
      end
      check("entries_written", entries_written_o, m_entries);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) tick(gap);
    byte_data_i  = b;
    byte_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!byte_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready_o) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: byte_ready_o got 0, required 1 for byte %0h", b);
      byte_valid_i = 1'b0;
      tick(1);
      return;
    end
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_entry(input logic [39:0] e, input int gapmax);
    for (int i = 0; i < 5; i++) begin
      send_byte(e[i*8 +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      chk ^= e[i*8 +: 8];
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] chk_delta, input int gapmax);
    logic [7:0]  cb;
    logic [36:0] r;
    cb = n[7:0];
    send_byte(8'hA5, 0);
    send_byte(cb, 0);
    chk = cb;
    for (int k = 0; k < n; k++) begin
      r[31:0]  = $urandom();
      r[36:32] = 5'($urandom_range(0, 31));
      exp_q.push_back(r);
      send_entry({3'b000, r}, gapmax);
    end
    send_byte(chk ^ chk_delta, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    exp_q.delete();
    m_entries = 0;
    wen_total = 0;
    #1;
    check("rst_ready", byte_ready_o, 0);
    check("rst_wen", lut_wen_o, 0);
    check("rst_entries", entries_written_o, 0);
    check("rst_wdata", lut_write_data_o, 0);
    check("rst_done_err", {config_done_o, error_o, error_code_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
  endtask

  initial begin
    reset_i      = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    abort_i      = 1'b0;

    // Reset values and ready rising one cycle after release.
    do_reset();
    @(negedge clk);
    check("ready_low_first_cycle", byte_ready_o, 0);
    tick(1);
    check("ready_rises", byte_ready_o, 1);

    // Single all-ones entry; CHK = 01^FF^FF^FF^FF^1F = 1E.
    exp_q.push_back(37'h1F_FFFF_FFFF);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h1F, 0);
    check("t1_done_before_chk", config_done_o, 0);
    send_byte(8'h1E, 0);
    check("t1_done", config_done_o, 1);
    check("t1_ready", byte_ready_o, 0);
    check("t1_entries", entries_written_o, 1);
    check("t1_wdata_lit", lut_write_data_o, 37'h1F_FFFF_FFFF);
    check("t1_error", error_o, 0);
    pulse_abort();
    tick(2);
    check("t1_abort_ignored_done", config_done_o, 1);
    check("t1_abort_ignored_ready", byte_ready_o, 0);
    check("t1_wen_total", wen_total, 1);
    check("t1_queue_drained", exp_q.size(), 0);

    // Garbage then a two-entry frame with random gaps; CHK hand-computed = 90.
    do_reset();
    tick(1);
    exp_q.push_back(37'h00_1234_5678);
    exp_q.push_back(37'h1A_BCDE_F012);
    send_byte(8'h00, 2);
    send_byte(8'h5A, 1);
    send_byte(8'hA5, 3);
    send_byte(8'h02, 1);
    send_entry(40'h00_1234_5678, 3);
    send_entry(40'h1A_BCDE_F012, 3);
    send_byte(8'h90, 2);
    check("t2_done", config_done_o, 1);
    check("t2_wen_total", wen_total, 2);
    check("t2_entries", entries_written_o, 2);
    check("t2_queue_drained", exp_q.size(), 0);
    check("t2_error", error_o, 0);

    // Reserved bit set in the second entry's last byte.
    do_reset();
    tick(1);
    exp_q.push_back(37'h00_1234_5678);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_entry(40'h00_1234_5678, 0);
    send_entry(40'h20_0000_0000, 0);
    check("t3_error", error_o, 1);
    check("t3_code", error_code_o, 1);
    check("t3_ready", byte_ready_o, 0);
    check("t3_entries", entries_written_o, 1);
    tick(3);
    check("t3_wen_total", wen_total, 1);
    pulse_abort();
    m_entries = 0;
    check("t3_abort_error", error_o, 0);
    check("t3_abort_code", error_code_o, 0);
    check("t3_abort_entries", entries_written_o, 0);
    check("t3_abort_ready", byte_ready_o, 1);

    // Checksum off by one: all writes issued, then code 2.
    w0 = wen_total;
    send_frame(3, 8'h01, 2);
    check("t4_error", error_o, 1);
    check("t4_code", error_code_o, 2);
    check("t4_done", config_done_o, 0);
    check("t4_writes", wen_total - w0, 3);
    check("t4_queue_drained", exp_q.size(), 0);
    pulse_abort();
    m_entries = 0;

    // COUNT = 00 means 256 entries.
    w0 = wen_total;
    send_frame(256, 8'h00, 0);
    check("t5_done", config_done_o, 1);
    check("t5_entries", entries_written_o, 256);
    check("t5_writes", wen_total - w0, 256);
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset mid-entry, then a fresh frame; CHK = 01^01^02^03^04^05 = 00.
    do_reset();
    tick(1);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    do_reset();
    tick(1);
    exp_q.push_back(37'h05_0403_0201);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_entry(40'h05_0403_0201, 1);
    send_byte(8'h00, 0);
    check("t6_done", config_done_o, 1);
    check("t6_wdata_lit", lut_write_data_o, 37'h05_0403_0201);
    check("t6_wen_total", wen_total, 1);
    check("t6_error", error_o, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
